// File: rtl/shift_reg_universal.sv
// Universal shift register: hold, shift/rotate in both directions, parallel load,
// synchronous clear, plus an autonomous LSB-first burst that serialises a loaded word.
module shift_reg_universal #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_clr,
  input  logic [2:0]       i_mode,
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_di,
  input  logic             i_start,
  output logic [WIDTH-1:0] o_q,
  output logic             o_do_c,
  output logic             o_busy,
  output logic             o_done
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHR  = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_ROR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_LOAD = 3'b101;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_q;
  logic               r_dir;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_done;

  logic [WIDTH-1:0]   w_shr;
  logic [WIDTH-1:0]   w_shl;
  logic [WIDTH-1:0]   w_ror;
  logic [WIDTH-1:0]   w_rol;

  // Candidate next values for every shift flavour
  assign w_shr = {i_di, r_q[WIDTH-1:1]};
  assign w_shl = {r_q[WIDTH-2:0], i_di};
  assign w_ror = {r_q[0], r_q[WIDTH-1:1]};
  assign w_rol = {r_q[WIDTH-2:0], r_q[WIDTH-1]};

  // State, datapath and burst sequencing; clr overrides everything
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_state <= ST_IDLE;
      r_q     <= RESET_VAL;
      r_dir   <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_q     <= i_d;
            r_dir   <= 1'b0;
            r_cnt   <= CNT_W'(WIDTH - 1);
            r_busy  <= 1'b1;
            r_state <= ST_SHIFT;
          end else begin
            case (i_mode)
              MODE_HOLD: r_q <= r_q;
              MODE_SHR: begin
                r_q   <= w_shr;
                r_dir <= 1'b0;
              end
              MODE_SHL: begin
                r_q   <= w_shl;
                r_dir <= 1'b1;
              end
              MODE_ROR: begin
                r_q   <= w_ror;
                r_dir <= 1'b0;
              end
              MODE_ROL: begin
                r_q   <= w_rol;
                r_dir <= 1'b1;
              end
              MODE_LOAD: r_q <= i_d;
              default:   r_q <= r_q;
            endcase
          end
        end
        ST_SHIFT: begin
          if (r_cnt != '0) begin
            r_q   <= w_shr;
            r_cnt <= r_cnt - CNT_W'(1);
          end else begin
            // Last burst cycle: a pending start chains the next burst with no gap
            r_done <= 1'b1;
            if (i_start) begin
              r_q   <= i_d;
              r_dir <= 1'b0;
              r_cnt <= CNT_W'(WIDTH - 1);
            end else begin
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_q    = r_q;
  assign o_busy = r_busy;
  assign o_done = r_done;
  // Shows the bit the next shift in the current direction will discard
  assign o_do_c = r_dir ? r_q[WIDTH-1] : r_q[0];

endmodule

// File: tb/tb_shift_reg_universal.sv
// Randomised + directed bench for shift_reg_universal against a word-level reference model.
module tb_shift_reg_universal;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         clr, di, start;
  logic [2:0]   mode;
  logic [W-1:0] d;
  logic [W-1:0] q, q2;
  logic         do_c, busy, done;
  logic         do2, busy2, done2;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [W-1:0] m_q;
  logic         m_dir, m_busy, m_done;
  int           m_left;
  logic         exp_bits[$];

  always #5 clk = ~clk;

  shift_reg_universal #(.WIDTH(W), .RESET_VAL(8'h00)) u_dut (
    .i_clk(clk), .i_clr(clr), .i_mode(mode), .i_d(d), .i_di(di), .i_start(start),
    .o_q(q), .o_do_c(do_c), .o_busy(busy), .o_done(done)
  );

  shift_reg_universal #(.WIDTH(W), .RESET_VAL(8'hA5)) u_dut_rv (
    .i_clk(clk), .i_clr(clr), .i_mode(mode), .i_d(d), .i_di(di), .i_start(start),
    .o_q(q2), .o_do_c(do2), .o_busy(busy2), .o_done(done2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Start a burst in the model: remember the word's bits in serial order
  task automatic model_load_burst(input logic [W-1:0] word);
    m_q    = word;
    m_dir  = 1'b0;
    m_busy = 1'b1;
    m_left = W;
    for (int i = 0; i < W; i++) exp_bits.push_back(word[i]);
  endtask

  // Advance model and DUT one edge, then compare all observable outputs
  task automatic tick();
    logic exp_do;
    if (clr) begin
      m_q = 8'h00; m_dir = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_left = 0;
      exp_bits.delete();
    end else if (m_busy) begin
      m_done = 1'b0;
      if (m_left > 1) begin
        m_q    = (m_q >> 1) | (W'(di) << (W - 1));
        m_left = m_left - 1;
      end else begin
        m_done = 1'b1;
        if (start) model_load_burst(d);
        else m_busy = 1'b0;
      end
    end else begin
      m_done = 1'b0;
      if (start) model_load_burst(d);
      else begin
        case (mode)
          3'd1: begin m_q = (m_q >> 1) | (W'(di) << (W - 1)); m_dir = 1'b0; end
          3'd2: begin m_q = (m_q << 1) | W'(di); m_dir = 1'b1; end
          3'd3: begin m_q = (m_q >> 1) | (m_q << (W - 1)); m_dir = 1'b0; end
          3'd4: begin m_q = (m_q << 1) | (m_q >> (W - 1)); m_dir = 1'b1; end
          3'd5: m_q = d;
          default: ;
        endcase
      end
    end
    @(posedge clk);
    #1;
    exp_do = m_dir ? m_q[W-1] : m_q[0];
    check("q", 32'(q), 32'(m_q));
    check("busy", 32'(busy), 32'(m_busy));
    check("done", 32'(done), 32'(m_done));
    check("do", 32'(do_c), 32'(exp_do));
    if (m_busy) begin
      if (exp_bits.size() == 0) check("burst_queue", 32'(0), 32'(1));
      else check("burst_do", 32'(do_c), 32'(exp_bits.pop_front()));
    end
  endtask

  initial begin
    logic [15:0] bits;
    int          nb;
    logic        got_done;

    m_q = '0; m_dir = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_left = 0;

    // Reset overrides load and start
    clr = 1'b1; mode = 3'b101; d = 8'hFF; start = 1'b1; di = 1'b1;
    tick();
    check("rst_q", 32'(q), 32'h00);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_q_rv", 32'(q2), 32'hA5);

    // Shifts
    clr = 1'b0; start = 1'b0; mode = 3'b101; d = 8'b1001_0110;
    tick();
    mode = 3'b001; di = 1'b1;
    tick();
    check("shr_q", 32'(q), 32'hCB);
    check("shr_do", 32'(do_c), 32'h1);
    mode = 3'b010; di = 1'b0;
    tick();
    check("shl_q", 32'(q), 32'h96);
    check("shl_do", 32'(do_c), 32'h1);

    // Rotates ignore di
    mode = 3'b101; d = 8'h81;
    tick();
    mode = 3'b011;
    for (int i = 0; i < 4; i++) begin di = ~di; tick(); end
    check("ror_q", 32'(q), 32'h18);
    mode = 3'b100;
    for (int i = 0; i < 4; i++) begin di = ~di; tick(); end
    check("rol_q", 32'(q), 32'h81);

    // Burst with mode=shift-left held throughout
    mode = 3'b010; start = 1'b1; d = 8'hB4;
    tick();
    start = 1'b0; d = 8'($urandom);
    bits = '0; nb = 0; got_done = 1'b0;
    for (int k = 0; k < 20 && !got_done; k++) begin
      if (busy) begin
        if (nb < 16) bits[nb] = do_c;
        nb++;
      end
      if (done) got_done = 1'b1;
      else begin di = 1'($urandom); tick(); end
    end
    check("burst_len", 32'(nb), 32'd8);
    check("burst_seq", 32'(bits), 32'h00B4);
    check("burst_done", 32'(got_done), 32'h1);
    check("burst_end_busy", 32'(busy), 32'h0);

    // Back-to-back burst, mid-burst start ignored, clr abandons burst
    mode = 3'b000; start = 1'b1; d = 8'hA3;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin di = 1'($urandom); tick(); end
    start = 1'b1; d = 8'h0F;
    tick();
    check("b2b_done", 32'(done), 32'h1);
    check("b2b_busy", 32'(busy), 32'h1);
    check("b2b_q", 32'(q), 32'h0F);
    d = 8'hFF; di = 1'b0;
    tick();
    check("midstart_q", 32'(q), 32'h07);
    check("midstart_busy", 32'(busy), 32'h1);
    start = 1'b0;
    tick();
    clr = 1'b1;
    tick();
    check("clr_q", 32'(q), 32'h00);
    check("clr_busy", 32'(busy), 32'h0);
    check("clr_done", 32'(done), 32'h0);
    check("clr_q_rv", 32'(q2), 32'hA5);
    clr = 1'b0;
    tick();
    check("clr_no_done", 32'(done), 32'h0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      clr   = ($urandom_range(0, 49) == 0);
      start = ($urandom_range(0, 9) == 0);
      mode  = 3'($urandom);
      d     = 8'($urandom);
      di    = 1'($urandom);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
